// File: rtl/pill_log_ram_scheduler.sv
// pill_log_ram_scheduler
//   Owns the single-port log RAM holding the 28-bit pill record. Zeroes the RAM
//   after reset, then writes periodic or forced snapshots of the record into a
//   circular buffer. A display/readback requester shares the port through a
//   request/ack handshake; pending writes always win.
//
//   Optional build macro: PILL_LOG_STOP_WHEN_FULL_EN
//     defined   - once DEPTH entries are stored, further snapshots are dropped
//                 (oldest entries kept), overflow is set
//     undefined - circular overwrite; the oldest entry is lost, overflow is set
//
//   state   | meaning
//   CLEAR   | zeroing RAM entries 0..DEPTH-1, triggers ignored, busy=1
//   IDLE    | waiting for a pending write or a read request
//   WRITE   | snapshot write presented on the RAM port
//   READ    | read address presented on the RAM port, rd_ack=1
//   RDWAIT  | RAM data returning, rd_valid=1

module pill_log_ram_scheduler #(
    parameter int DATA_W     = 28,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int LOG_PERIOD = 60
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sec_tick,
    input  logic [DATA_W-1:0] i_log_data,
    input  logic              i_log_force,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W:0]   o_log_count,
    output logic              o_overflow,
    output logic              o_busy
);

    localparam int                PCNT_W    = (LOG_PERIOD > 1) ? $clog2(LOG_PERIOD) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(LOG_PERIOD - 1);
    localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDWAIT
    } state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_clr_addr;
    logic [PCNT_W-1:0]   r_period_cnt;
    logic                r_wr_pend;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_rd_ack;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_log_count;
    logic                r_overflow;
    logic                r_busy;

    logic                w_trig;
    logic                w_full;
    logic                w_store;

    // A snapshot is requested by a force pulse or by the last tick of a period.
    assign w_trig = (r_state != S_CLEAR) &&
                    (i_log_force || (i_sec_tick && (r_period_cnt == PCNT_LAST)));
    assign w_full = (r_log_count == FULL);
`ifdef PILL_LOG_STOP_WHEN_FULL_EN
    assign w_store = !w_full;
`else
    assign w_store = 1'b1;
`endif

    // Seconds counter between automatic snapshots; a force restarts the period.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_period_cnt <= '0;
        end else if (r_state != S_CLEAR) begin
            if (i_log_force) begin
                r_period_cnt <= '0;
            end else if (i_sec_tick) begin
                r_period_cnt <= (r_period_cnt == PCNT_LAST) ? '0 : r_period_cnt + 1'b1;
            end
        end
    end

    // Pending-write flag: triggers merge while pending, a trigger in WRITE re-arms.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_pend <= 1'b0;
        end else if (r_state == S_WRITE) begin
            r_wr_pend <= w_trig;
        end else if (w_trig) begin
            r_wr_pend <= 1'b1;
        end
    end

    // Port arbiter FSM; RAM and handshake outputs are registered on state entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_wr_ptr    <= '0;
            r_log_count <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr == FULL) begin
                        r_state    <= S_IDLE;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_clr_addr[ADDR_W-1:0];
                        r_ram_wdata <= '0;
                        r_clr_addr  <= r_clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_wr_pend) begin
                        r_state     <= S_WRITE;
                        r_ram_we    <= w_store;
                        r_ram_addr  <= r_wr_ptr;
                        r_ram_wdata <= i_log_data;
                    end else if (i_rd_req) begin
                        r_state    <= S_READ;
                        r_rd_ack   <= 1'b1;
                        r_ram_addr <= i_rd_addr;
                    end
                end
                S_WRITE: begin
                    r_state     <= S_IDLE;
                    r_ram_we    <= 1'b0;
                    r_ram_addr  <= '0;
                    r_ram_wdata <= '0;
                    if (w_store) begin
                        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_log_count <= r_log_count + 1'b1;
                    end
                end
                S_READ: begin
                    r_state    <= S_RDWAIT;
                    r_rd_ack   <= 1'b0;
                    r_ram_addr <= '0;
                    r_rd_valid <= 1'b1;
                end
                S_RDWAIT: begin
                    r_state    <= S_IDLE;
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= i_ram_rdata;
                end
                default: begin
                    r_state    <= S_CLEAR;
                    r_clr_addr <= '0;
                    r_ram_we   <= 1'b0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    // RAM data arrives during RDWAIT, so it is passed straight through while
    // rd_valid is high and held afterwards.
    assign o_rd_data   = r_rd_valid ? i_ram_rdata : r_rd_data;
    assign o_rd_ack    = r_rd_ack;
    assign o_rd_valid  = r_rd_valid;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_log_count = r_log_count;
    assign o_overflow  = r_overflow;
    assign o_busy      = r_busy;

endmodule
